// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift-register command sequencer.
// The rotate variant of the sequencer is selected with SHIFT_ROTATE_EN.
package shift_ctrl_pkg;

  // Encodings match the {S0,S1} mode select of the shift register.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command channel into the shift sequencer.
// Handshake: a command transfers on a rising edge where CMD_VALID & CMD_READY;
// the master holds OP/CNT/FILL/DATA stable while CMD_VALID is high and not yet accepted.
interface shift_seq_ctrl_if #(
  parameter int C_NUM_BITS = 4,
  parameter int C_CNT_BITS = $clog2(C_NUM_BITS + 1)
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [1:0]            CMD_OP;
  logic [C_CNT_BITS-1:0] CMD_CNT;
  logic                  CMD_FILL;
  logic [C_NUM_BITS-1:0] CMD_DATA;

  modport master (
    output CMD_VALID, CMD_OP, CMD_CNT, CMD_FILL, CMD_DATA,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_CNT, CMD_FILL, CMD_DATA,
    output CMD_READY
  );
endinterface

// File: rtl/shift_seq_ctrl_cnt.sv
// Loadable down-counter for the shift sequencer; the load value is clamped to
// the register width and 'last' flags the final count of an EXEC run.
module shift_cnt #(
  parameter int C_NUM_BITS = 4,
  parameter int C_CNT_BITS = $clog2(C_NUM_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [C_CNT_BITS-1:0] load_val,
  input  logic                  dec,
  output logic                  last
);

  localparam logic [C_CNT_BITS-1:0] MAX_CNT = C_CNT_BITS'(C_NUM_BITS);

  logic [C_CNT_BITS-1:0] count;
  logic [C_CNT_BITS-1:0] clamped;

  assign clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;
  assign last    = (count == C_CNT_BITS'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= clamped;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer that drives univ_shift_reg for a counted number of edges.
// Define SHIFT_ROTATE_EN to feed the shifted-out bit back in instead of CMD_FILL.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int C_NUM_BITS = 4,
  parameter int C_CNT_BITS = $clog2(C_NUM_BITS + 1)
) (
  input  logic                  CK,
  input  logic                  RN,
  shift_seq_ctrl_if.slave       cmd,
  input  logic [C_NUM_BITS-1:0] Q,
  output logic                  S0,
  output logic                  S1,
  output logic                  SRI,
  output logic                  SLI,
  output logic [C_NUM_BITS-1:0] D,
  output logic                  BUSY,
  output logic                  DONE,
  output state_e                state_dbg
);

  state_e                state_q, state_d;
  op_e                   op_q;
  op_e                   cmd_op;
  logic [C_NUM_BITS-1:0] d_q;
  logic                  accept;
  logic                  cnt_last;
  logic [C_CNT_BITS-1:0] cnt_load_val;
  logic                  fill_l;
  logic                  fill_r;

  assign cmd_op        = op_e'(cmd.CMD_OP);
  assign cmd.CMD_READY = (state_q == ST_IDLE);
  assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
  assign cnt_load_val  = (cmd_op == OP_LOAD) ? C_CNT_BITS'(1) : cmd.CMD_CNT;

  shift_cnt #(
    .C_NUM_BITS (C_NUM_BITS),
    .C_CNT_BITS (C_CNT_BITS)
  ) u_cnt (
    .clk      (CK),
    .rst_n    (RN),
    .load     (accept),
    .load_val (cnt_load_val),
    .dec      (state_q == ST_EXEC),
    .last     (cnt_last)
  );

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        if (cmd_op == OP_LOAD) d_q <= cmd.CMD_DATA;
      end
    end
  end

`ifdef SHIFT_ROTATE_EN
  // Rotate: the bit leaving one end re-enters the other.
  logic unused_fill;
  assign unused_fill = cmd.CMD_FILL;
  assign fill_l      = Q[0];
  assign fill_r      = Q[C_NUM_BITS-1];
`else
  logic fill_q;
  logic unused_q;
  assign unused_q = ^Q;

  always_ff @(posedge CK) begin
    if (!RN)         fill_q <= 1'b0;
    else if (accept) fill_q <= cmd.CMD_FILL;
  end

  assign fill_l = fill_q;
  assign fill_r = fill_q;
`endif

  // NOP and zero-count shifts never touch the register: go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((cmd_op == OP_NOP) ||
              ((cmd_op != OP_LOAD) && (cmd.CMD_CNT == '0)))
            state_d = ST_DONE;
          else
            state_d = ST_EXEC;
        end
      end
      ST_EXEC: if (cnt_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    S0  = 1'b0;
    S1  = 1'b0;
    SRI = 1'b0;
    SLI = 1'b0;
    if (state_q == ST_EXEC) begin
      {S0, S1} = op_q;
      if (op_q == OP_SHL) SLI = fill_l;
      if (op_q == OP_SHR) SRI = fill_r;
    end
  end

  assign D         = d_q;
  assign BUSY      = (state_q == ST_EXEC) || (state_q == ST_DONE);
  assign DONE      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a behavioural univ_shift_reg model.
module tb_shift_seq_ctrl;
  import shift_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic RN;
  always #5 CK = ~CK;

  shift_seq_ctrl_if #(.C_NUM_BITS(N)) cmd_if ();

  logic [N-1:0] Q;
  logic [N-1:0] D;
  logic         S0, S1, SRI, SLI, BUSY, DONE;
  state_e       state_dbg;

  shift_seq_ctrl #(.C_NUM_BITS(N)) dut (
    .CK        (CK),
    .RN        (RN),
    .cmd       (cmd_if),
    .Q         (Q),
    .S0        (S0),
    .S1        (S1),
    .SRI       (SRI),
    .SLI       (SLI),
    .D         (D),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .state_dbg (state_dbg)
  );

  // Shift register: 01 moves bits toward LSB with SLI at MSB,
  // 10 moves bits toward MSB with SRI at LSB, 11 loads D.
  always @(posedge CK) begin
    if (!RN) Q <= '0;
    else begin
      case ({S0, S1})
        2'b01:   Q <= {SLI, Q[N-1:1]};
        2'b10:   Q <= {Q[N-2:0], SRI};
        2'b11:   Q <= D;
        default: Q <= Q;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] last_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic          fill;
    logic [N-1:0]  data;
    int            exp_exec;
    logic [N-1:0]  exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input int cnt, input logic fill,
                              input logic [N-1:0] data, input int exp_exec,
                              input logic [N-1:0] exp_q);
    vec_t v;
    v.op = op; v.cnt = CW'(cnt); v.fill = fill; v.data = data;
    v.exp_exec = exp_exec; v.exp_q = exp_q;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic [1:0] op, input logic [CW-1:0] cnt,
                           input logic fill, input logic [N-1:0] data);
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_CNT   = cnt;
    cmd_if.CMD_FILL  = fill;
    cmd_if.CMD_DATA  = data;
    cmd_if.CMD_VALID = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int  wait_cyc;
    int  exec_n;
    int  done_cyc;
    bit  done_seen;
    wait_cyc = 0;
    @(negedge CK);
    while (!cmd_if.CMD_READY && wait_cyc < 20) begin
      @(negedge CK);
      wait_cyc++;
    end
    check($sformatf("v%0d_ready", idx), cmd_if.CMD_READY, 1);
    drive_cmd(v.op, v.cnt, v.fill, v.data);
    if (v.op == 2'b11) last_d = v.data;
    @(posedge CK);
    exec_n = 0; done_seen = 0; done_cyc = -1;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge CK);
      if (c == 0) cmd_if.CMD_VALID = 1'b0;
      if (DONE) begin
        done_seen = 1;
        done_cyc  = c;
        check($sformatf("v%0d_done_s0s1", idx), {S0, S1}, 2'b00);
        check($sformatf("v%0d_done_ready", idx), cmd_if.CMD_READY, 0);
        check($sformatf("v%0d_q", idx), Q, v.exp_q);
        check($sformatf("v%0d_d", idx), D, last_d);
      end else if ({S0, S1} != 2'b00) begin
        exec_n++;
        check($sformatf("v%0d_exec_op", idx), {S0, S1}, v.op);
        check($sformatf("v%0d_exec_busy", idx), BUSY, 1);
      end
    end
    check($sformatf("v%0d_done_seen", idx), done_seen, 1);
    check($sformatf("v%0d_exec_cycles", idx), exec_n, v.exp_exec);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_exec);
    @(negedge CK);
    check($sformatf("v%0d_done_pulse", idx), DONE, 0);
    check($sformatf("v%0d_ready_after", idx), cmd_if.CMD_READY, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    bit done_after_abort;
    RN = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'b00;
    cmd_if.CMD_CNT   = '0;
    cmd_if.CMD_FILL  = 1'b0;
    cmd_if.CMD_DATA  = '0;

`ifdef SHIFT_ROTATE_EN
    vecs.push_back(mk(2'b11, 0, 1'b0, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(2'b10, 4, 1'b0, 4'b0000, 4, 4'b1000));
    vecs.push_back(mk(2'b01, 1, 1'b1, 4'b0000, 1, 4'b0100));
    vecs.push_back(mk(2'b10, 2, 1'b1, 4'b0000, 2, 4'b0001));
    vecs.push_back(mk(2'b01, 0, 1'b1, 4'b0000, 0, 4'b0001));
    vecs.push_back(mk(2'b00, 3, 1'b0, 4'b0000, 0, 4'b0001));
`else
    vecs.push_back(mk(2'b11, 0, 1'b0, 4'b1011, 1, 4'b1011));
    vecs.push_back(mk(2'b10, 2, 1'b0, 4'b0000, 2, 4'b1100));
    vecs.push_back(mk(2'b11, 0, 1'b0, 4'b1011, 1, 4'b1011));
    vecs.push_back(mk(2'b01, 7, 1'b1, 4'b0000, 4, 4'b1111));
    vecs.push_back(mk(2'b01, 0, 1'b1, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(2'b00, 3, 1'b0, 4'b0110, 0, 4'b1111));
    vecs.push_back(mk(2'b11, 0, 1'b0, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(2'b01, 1, 1'b0, 4'b0000, 1, 4'b0001));
    vecs.push_back(mk(2'b10, 3, 1'b1, 4'b0000, 3, 4'b1111));
    vecs.push_back(mk(2'b10, 4, 1'b0, 4'b0000, 4, 4'b0000));
    vecs.push_back(mk(2'b01, 3, 1'b1, 4'b0000, 3, 4'b1110));
    vecs.push_back(mk(2'b10, 5, 1'b0, 4'b0000, 4, 4'b0000));
`endif

    // Reset state
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("rst_s0s1",  {S0, S1}, 2'b00);
    check("rst_sri_sli", {SRI, SLI}, 2'b00);
    check("rst_d",     D, 0);
    check("rst_ready", cmd_if.CMD_READY, 1);
    check("rst_busy",  BUSY, 0);
    check("rst_done",  DONE, 0);
    check("rst_state", state_dbg, ST_IDLE);
    RN = 1'b1;

    foreach (vecs[i]) run_cmd(vecs[i], i);

    // Command held valid through DONE waits one more edge.
    @(negedge CK);
    drive_cmd(2'b11, '0, 1'b0, 4'b0101);
    last_d = 4'b0101;
    @(posedge CK);
    @(negedge CK);
    cmd_if.CMD_OP = 2'b00;
    check("b2b_exec_s0s1", {S0, S1}, 2'b11);
    check("b2b_exec_ready", cmd_if.CMD_READY, 0);
    @(negedge CK);
    check("b2b_done1", DONE, 1);
    check("b2b_done1_ready", cmd_if.CMD_READY, 0);
    check("b2b_q", Q, 4'b0101);
    @(negedge CK);
    check("b2b_idle_ready", cmd_if.CMD_READY, 1);
    check("b2b_idle_done", DONE, 0);
    @(negedge CK);
    cmd_if.CMD_VALID = 1'b0;
    check("b2b_nop_done", DONE, 1);
    check("b2b_nop_s0s1", {S0, S1}, 2'b00);
    check("b2b_nop_q", Q, 4'b0101);
    check("b2b_nop_d", D, 4'b0101);
    @(negedge CK);
    check("b2b_end_state", state_dbg, ST_IDLE);

    // Reset during the third of four shifts aborts without DONE.
    drive_cmd(2'b11, '0, 1'b0, 4'b0000);
    @(posedge CK);
    @(negedge CK);
    cmd_if.CMD_VALID = 1'b0;
    repeat (2) @(negedge CK);
    check("abort_pre_ready", cmd_if.CMD_READY, 1);
    drive_cmd(2'b01, CW'(4), 1'b1, 4'b0000);
    @(posedge CK);
    @(negedge CK);
    cmd_if.CMD_VALID = 1'b0;
    check("abort_shift1", {S0, S1}, 2'b01);
    @(negedge CK);
    @(negedge CK);
    check("abort_shift3", {S0, S1}, 2'b01);
`ifndef SHIFT_ROTATE_EN
    check("abort_q_mid", Q, 4'b1100);
`endif
    RN = 1'b0;
    @(negedge CK);
    RN = 1'b1;
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_done", DONE, 0);
    check("abort_busy", BUSY, 0);
    check("abort_ready", cmd_if.CMD_READY, 1);
    check("abort_s0s1", {S0, S1}, 2'b00);
    check("abort_d", D, 0);
    done_after_abort = 0;
    repeat (6) begin
      @(negedge CK);
      if (DONE) done_after_abort = 1;
    end
    check("abort_no_done", done_after_abort, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
